piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in serial-out shift register; the transmit-side counterpart to the `sipo` deserializer.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock on `sout`.
- Provides frame markers so that a downstream `sipo` or serial link can delimit words.
- Supports gapless back-to-back words: the next word loads during the last bit of the current word.

Parameters:
- WIDTH, 4, word width in bits; legal range 2 to 32.
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.
- IDLE_LEVEL, 0, value driven on `sout` when no word is being transmitted.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- pdata  input  WIDTH  parallel word to transmit
- pvalid  input  1  pdata is valid
- pready  output  1  block can accept a word this cycle
- sout  output  1  serial data bit
- sout_valid  output  1  sout carries a data bit this cycle
- first  output  1  sout carries the first bit of a word
- last  output  1  sout carries the final bit of a word
- busy  output  1  a word is in flight (state SHIFT)

Behaviour:
- Single clock domain `clk`; synchronous, active-high `reset`.
- State machine states are IDLE and SHIFT.
- Internal registers:
  - shift register `shreg[WIDTH-1:0]`
  - bit counter `bitcnt`, width clog2(WIDTH)
  - state register
- All outputs except `pready` are registered.
- Reset values:
  - state = IDLE, shreg = 0, bitcnt = 0
  - sout = IDLE_LEVEL, sout_valid = 0, first = 0, last = 0, busy = 0
- `pready` rules:
  - pready is combinational: 1 in IDLE, or in SHIFT when bitcnt == WIDTH-1; 0 otherwise.
  - pready is forced to 0 while `reset` is high.
  - pready never depends on `pvalid`.
- Accept: a word is taken on a rising edge where pvalid && pready. At that edge:
  - shreg <= pdata
  - bitcnt <= 0
  - state <= SHIFT
- Latency: the first bit appears on `sout` in the cycle immediately after the accepting edge (1 cycle). The word occupies exactly WIDTH consecutive cycles.
- In SHIFT, on each cycle:
  - sout = shreg[WIDTH-1] if MSB_FIRST, else shreg[0].
  - sout_valid = 1, busy = 1.
  - first = (bitcnt == 0).
  - last = (bitcnt == WIDTH-1).
- SHIFT transitions on each edge:
  - If bitcnt < WIDTH-1: shift shreg toward the output end, filling with 0, and bitcnt += 1.
  - If bitcnt == WIDTH-1 and pvalid: accept the new word (gapless). sout_valid stays 1 with no idle bit, and `first` asserts next cycle.
  - If bitcnt == WIDTH-1 and !pvalid: state <= IDLE. Next cycle sout = IDLE_LEVEL, sout_valid = 0, busy = 0, first = 0, last = 0.
- pdata changes after the accepting edge have no effect on the word in flight.
- pvalid without pready: ignored. No latching occurs; the upstream source holds the word.
- Reset mid-word: the word is discarded. The cycle after reset deasserts shows idle outputs, with no residual bits.
- Reset on the same edge as an accept: reset wins and the word is dropped.
- WIDTH == 2: bitcnt is 1 bit; first and last alternate on consecutive cycles.

Test Plan:
1. Single word, WIDTH=4, MSB_FIRST=1. Accept pdata=4'b1011 at edge N -> sout = 1,0,1,1 on cycles N+1..N+4; first only at N+1; last only at N+4; sout_valid = 1 for exactly 4 cycles; at N+5 sout = 0 and busy = 0.
2. Back-to-back words. Hold pvalid high with 4'hA then 4'h5 -> 8 contiguous valid bits 1,0,1,0,0,1,0,1; first at bits 1 and 5; last at bits 4 and 8; pready high only in IDLE and on bit cycles 4 and 8.
3. LSB-first with idle level. MSB_FIRST=0, IDLE_LEVEL=1, pdata=4'b0011 -> sout = 1,1,0,0; idle sout = 1 before and after the word.
4. Backpressure. Raise pvalid with 4'h6 during bit 2 of word 4'h9 -> not accepted until bit 4 (pready=1 then); 4'h6 begins on the next cycle with no gap.
5. Reset mid-word. Assert reset during bit 2 of 4'hF -> next cycle sout_valid = 0, sout = IDLE_LEVEL; the following accept of 4'h3 transmits cleanly as 0,0,1,1.
6. Loopback. Drive sout into the team's `sipo` (sinp = sout, shared clk/reset); send 4'hC -> 4 cycles after first asserts, sipo out == 4'hC. Repeat for all 16 values.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with valid/ready load and frame markers.
// The next word can load during the last bit of the current one, so words can follow with no gap.
module piso_serializer #(
  parameter int WIDTH      = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pdata,
  input  logic             pvalid,
  output logic             pready,
  output logic             sout,
  output logic             sout_valid,
  output logic             first,
  output logic             last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             at_last;
  logic             accept;
  logic             in_shift;

  assign at_last = (state_q == SHIFT) && (bitcnt_q == LAST_CNT);
  assign pready  = !reset && ((state_q == IDLE) || at_last);
  assign accept  = pvalid && pready;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    if (accept) begin
      shreg_d  = pdata;
      bitcnt_d = '0;
      state_d  = SHIFT;
    end else if (state_q == SHIFT) begin
      if (at_last) begin
        state_d = IDLE;
      end else begin
        if (MSB_FIRST) shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        else           shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
        bitcnt_d = bitcnt_q + CW'(1);
      end
    end

    // Registered outputs are derived from the next state so they line up with it.
    in_shift     = (state_d == SHIFT);
    sout_valid_d = in_shift;
    busy_d       = in_shift;
    first_d      = in_shift && (bitcnt_d == '0);
    last_d       = in_shift && (bitcnt_d == LAST_CNT);
    if (!in_shift)      sout_d = IDLE_LEVEL;
    else if (MSB_FIRST) sout_d = shreg_d[WIDTH-1];
    else                sout_d = shreg_d[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      sout_q       <= IDLE_LEVEL;
      sout_valid_q <= 1'b0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      first_q      <= first_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign first      = first_q;
  assign last       = last_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three configurations share stimulus and are checked
// every cycle against a word/bit-index reference model, plus a loopback reassembly check.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       pvalid;
  logic [3:0] pdata;
  logic [2:0] pr, so, sv, fi, la, bu;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .reset(reset), .pdata(pdata), .pvalid(pvalid), .pready(pr[0]),
    .sout(so[0]), .sout_valid(sv[0]), .first(fi[0]), .last(la[0]), .busy(bu[0]));

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
    .clk(clk), .reset(reset), .pdata(pdata), .pvalid(pvalid), .pready(pr[1]),
    .sout(so[1]), .sout_valid(sv[1]), .first(fi[1]), .last(la[1]), .busy(bu[1]));

  piso_serializer #(.WIDTH(2), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_w2 (
    .clk(clk), .reset(reset), .pdata(pdata[1:0]), .pvalid(pvalid), .pready(pr[2]),
    .sout(so[2]), .sout_valid(sv[2]), .first(fi[2]), .last(la[2]), .busy(bu[2]));

  int W[3]  = '{4, 4, 2};
  bit MF[3] = '{1'b1, 1'b0, 1'b1};
  bit IL[3] = '{1'b0, 1'b1, 1'b0};

  // Reference model: is a word active, which bit index of it is on the wire, and the word itself.
  bit         act[3];
  int         pos[3];
  logic [3:0] word[3];
  int         acc[3];
  int         nb[3];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 3; i++) begin
      int   bi;
      logic eb;
      bi = MF[i] ? (W[i] - 1 - pos[i]) : pos[i];
      eb = act[i] ? word[i][bi] : IL[i];
      chk($sformatf("sout[%0d]", i),       32'(so[i]), 32'(eb));
      chk($sformatf("sout_valid[%0d]", i), 32'(sv[i]), 32'(act[i]));
      chk($sformatf("busy[%0d]", i),       32'(bu[i]), 32'(act[i]));
      chk($sformatf("first[%0d]", i),      32'(fi[i]), 32'(act[i] && pos[i] == 0));
      chk($sformatf("last[%0d]", i),       32'(la[i]), 32'(act[i] && pos[i] == W[i] - 1));
      // Loopback: rebuild the word from the wire as a downstream deserializer would.
      if (sv[i] === 1'b1) begin
        if (fi[i] === 1'b1) begin
          acc[i] = 0;
          nb[i]  = 0;
        end
        if (MF[i]) acc[i] = (acc[i] << 1) | int'(so[i]);
        else       acc[i] = acc[i] | (int'(so[i]) << nb[i]);
        nb[i]++;
        if (la[i] === 1'b1) begin
          chk($sformatf("loop_word[%0d]", i), 32'(acc[i]), 32'(word[i]));
          chk($sformatf("loop_len[%0d]", i),  32'(nb[i]),  32'(W[i]));
        end
      end
    end
  endtask

  function automatic bit model_ready(input int i);
    return !reset && (!act[i] || pos[i] == W[i] - 1);
  endfunction

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        act[i] = 1'b0;
        pos[i] = 0;
      end else if (pvalid && model_ready(i)) begin
        word[i] = pdata & 4'((1 << W[i]) - 1);
        act[i]  = 1'b1;
        pos[i]  = 0;
      end else if (act[i]) begin
        if (pos[i] < W[i] - 1) pos[i]++;
        else act[i] = 1'b0;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [3:0] d);
    @(negedge clk);
    check_outputs();
    reset  = r;
    pvalid = v;
    pdata  = d;
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("pready[%0d]", i), 32'(pr[i]), 32'(model_ready(i)));
    @(posedge clk);
    model_step();
  endtask

  initial begin
    reset  = 1'b1;
    pvalid = 1'b0;
    pdata  = 4'h0;
    for (int i = 0; i < 3; i++) begin
      act[i] = 1'b0; pos[i] = 0; word[i] = '0; acc[i] = 0; nb[i] = 0;
    end
    repeat (2) @(posedge clk);
    cyc(1'b1, 1'b0, 4'h0);

    // Single word, then idle.
    cyc(1'b0, 1'b1, 4'b1011);
    repeat (6) cyc(1'b0, 1'b0, 4'h0);

    // Back-to-back: A then 5 held until taken.
    cyc(1'b0, 1'b1, 4'hA);
    repeat (4) cyc(1'b0, 1'b1, 4'h5);
    repeat (6) cyc(1'b0, 1'b0, 4'h0);

    // LSB-first pattern with idle-high instance.
    cyc(1'b0, 1'b1, 4'b0011);
    repeat (6) cyc(1'b0, 1'b0, 4'h0);

    // Backpressure: 6 raised during bit 2 of 9.
    cyc(1'b0, 1'b1, 4'h9);
    cyc(1'b0, 1'b0, 4'h0);
    repeat (3) cyc(1'b0, 1'b1, 4'h6);
    repeat (6) cyc(1'b0, 1'b0, 4'h0);

    // Reset mid-word, then a clean word; also reset coincident with a load attempt.
    cyc(1'b0, 1'b1, 4'hF);
    cyc(1'b0, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 4'h0);
    cyc(1'b0, 1'b1, 4'h3);
    repeat (5) cyc(1'b0, 1'b0, 4'h0);
    cyc(1'b1, 1'b1, 4'hC);
    repeat (3) cyc(1'b0, 1'b0, 4'h0);

    // Every value once, gapless.
    for (int v = 0; v < 16; v++) repeat (4) cyc(1'b0, 1'b1, 4'(v));
    repeat (6) cyc(1'b0, 1'b0, 4'h0);

    // Random traffic.
    for (int n = 0; n < 600; n++)
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6), 4'($urandom));
    repeat (6) cyc(1'b0, 1'b0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
